mc_data_path: RTL and testbench
===============================

Name: mc_data_path

Overview:
Parametrised multi-cycle MIPS datapath, the successor to the single-cycle Data_path.
- Adds an instruction register (IR), memory data register (MDR), A/B operand registers and an ALUOut register, so one shared memory port and one ALU serve all instruction phases.
- Adds jal/jr support and a configurable data width.
- An external multi-cycle control FSM drives every control input below, one phase per clock.

Parameters:
DW, 32, datapath/register width in bits; legal values 32 or 64; the instruction word is always 32 bits.
REG_NUM, 32, number of general registers; index width is clog2(REG_NUM), maximum 32.
RESET_PC, 0, value loaded into PC on reset.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset
PCWrite  in  1  unconditional PC write
PCWriteCond  in  1  conditional (branch) PC write
BranchNE  in  1  0 = beq sense, 1 = bne sense
IorD  in  1  memory address select: 0 = PC, 1 = ALUOut
IRWrite  in  1  load IR from Data_in[31:0]
RegDst  in  2  destination register: 00 = rt, 01 = rd, 10 = register 31
MemtoReg  in  2  write-back data: 00 = ALUOut, 01 = MDR, 10 = PC
RegWrite  in  1  register file write enable
ALUSrcA  in  1  ALU A operand: 0 = PC, 1 = A
ALUSrcB  in  2  ALU B operand: 00 = B, 01 = DW/8, 10 = sext(imm16), 11 = sext(imm16)<<2
ALU_Control  in  3  ALU operation code
PCSource  in  2  next PC: 00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = A
Data_in  in  DW  memory read data
M_addr  out  DW  memory address
Data_out  out  DW  memory write data (= B)
inst_out  out  32  IR contents
PC_out  out  DW  current PC
ALU_out  out  DW  combinational ALU result
zero  out  1  ALU result == 0
overflow  out  1  signed overflow on ADD/SUB

Behaviour:
- Reset (rst low, asynchronous):
  - PC = RESET_PC; IR, MDR, A, B, ALUOut and all registers = 0.
  - Releasing reset mid-instruction restarts execution cleanly at RESET_PC.
- Register captures every clock (no enable): MDR <= Data_in; A <= R[IR[25:21]]; B <= R[IR[20:16]]; ALUOut <= ALU result.
- IR: IR <= Data_in[31:0] only when IRWrite is high.
- Register file:
  - Two asynchronous read ports; one write port on the clock edge when RegWrite is high.
  - Register 0 reads as 0 and ignores writes.
  - Write and read of the same register in one cycle: the read returns the old value.
- ALU_Control codes:
  - 000 AND, 001 OR, 010 ADD, 011 XOR, 100 NOR, 110 SUB
  - 111 SLT (signed, result 1 or 0), 101 SLTU
  - zero always reflects the current ALU result.
  - overflow is valid only for ADD/SUB; it is 0 for all other codes.
- Sign extension: sext(imm16) replicates IR[15] up to DW bits.
- Jump target: {PC[DW-1:28], IR[25:0], 2'b00}.
- PC update: PC <= next PC when PCWrite | (PCWriteCond & (zero ^ BranchNE)).
  - PCWrite and PCWriteCond both high: PCWrite wins and the write is unconditional.
- M_addr = IorD ? ALUOut : PC (combinational).
- RegDst = 11 and MemtoReg = 11 are reserved: they select rt and ALUOut respectively.
- All arithmetic wraps modulo 2^DW; PC wraps from all-ones to 0 without error.

Test Plan:
1. Reset, then fetch phase: rst low then high; IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALU_Control=010, PCSource=00, PCWrite=1, Data_in=0x2008_0005 -> M_addr=0 before the edge; after the edge inst_out=0x2008_0005 and PC_out=4.
2. addi write-back: decode, execute (ALUSrcA=1, ALUSrcB=10, ADD), then RegDst=00, MemtoReg=00, RegWrite=1 -> R8=5. R0 write attempt -> R0 still reads 0.
3. beq/bne: R8=R9=5; SUB with PCWriteCond=1 and ALUOut holding PC+8 -> PC taken when BranchNE=0; same setup with BranchNE=1 -> PC unchanged.
4. jal then jr: IR=0x0C00_0010, PCSource=10, RegDst=10, MemtoReg=10 -> PC=0x40 and R31=old PC. Then PCSource=11 with A=R31 -> PC returns to the saved value.
5. Load path: IorD=1, ALUOut=0x100, Data_in=0xDEAD_BEEF, MemtoReg=01 -> M_addr=0x100 and rt=0xDEAD_BEEF.
6. ALU edges and async reset:
   - 0x7FFF_FFFF+1 -> overflow=1.
   - SLT(-1,1)=1; SLTU(-1,1)=0.
   - rst pulsed low mid-cycle (no clock edge) -> PC=RESET_PC immediately.
   - Rerun scenarios 1-5 with DW=64.

Source files
------------

// File: rtl/mc_data_path.sv
// mc_data_path: multi-cycle MIPS datapath with IR/MDR/A/B/ALUOut staging registers,
// one shared memory port and one ALU, sequenced by an external control FSM.
module mc_data_path #(
    parameter int DW = 32,
    parameter int REG_NUM = 32,
    parameter logic [DW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          PCWrite,
    input  logic          PCWriteCond,
    input  logic          BranchNE,
    input  logic          IorD,
    input  logic          IRWrite,
    input  logic [1:0]    RegDst,
    input  logic [1:0]    MemtoReg,
    input  logic          RegWrite,
    input  logic          ALUSrcA,
    input  logic [1:0]    ALUSrcB,
    input  logic [2:0]    ALU_Control,
    input  logic [1:0]    PCSource,
    input  logic [DW-1:0] Data_in,
    output logic [DW-1:0] M_addr,
    output logic [DW-1:0] Data_out,
    output logic [31:0]   inst_out,
    output logic [DW-1:0] PC_out,
    output logic [DW-1:0] ALU_out,
    output logic          zero,
    output logic          overflow
);
    localparam int AW = REG_NUM > 1 ? $clog2(REG_NUM) : 1;

    logic [DW-1:0] pc, mdr, a, b, alu_out_r;
    logic [31:0]   ir;
    logic [DW-1:0] regs [REG_NUM];
    logic [AW-1:0] rs, rt, rd, wa;
    logic [DW-1:0] sext, src_a, src_b, sum, diff, res, wd, npc;
    logic          add_ov, sub_ov, pc_en;
    logic          unused;

    assign rs = ir[21 +: AW];
    assign rt = ir[16 +: AW];
    assign rd = ir[11 +: AW];
    assign wa = RegDst == 2'b01 ? rd : RegDst == 2'b10 ? AW'(31) : rt;
    assign wd = MemtoReg == 2'b01 ? mdr : MemtoReg == 2'b10 ? pc : alu_out_r;

    assign sext  = {{(DW-16){ir[15]}}, ir[15:0]};
    assign src_a = ALUSrcA ? a : pc;
    assign src_b = ALUSrcB == 2'b00 ? b :
                   ALUSrcB == 2'b01 ? DW'(DW / 8) :
                   ALUSrcB == 2'b10 ? sext : sext << 2;

    assign sum  = src_a + src_b;
    assign diff = src_a - src_b;
    assign res  = ALU_Control == 3'b000 ? src_a & src_b :
                  ALU_Control == 3'b001 ? src_a | src_b :
                  ALU_Control == 3'b010 ? sum :
                  ALU_Control == 3'b011 ? src_a ^ src_b :
                  ALU_Control == 3'b100 ? ~(src_a | src_b) :
                  ALU_Control == 3'b110 ? diff :
                  ALU_Control == 3'b111 ? DW'($signed(src_a) < $signed(src_b)) :
                  DW'(src_a < src_b);

    // Overflow: operands agree in sign (add) or differ (sub) and the result sign flips.
    assign add_ov   = (src_a[DW-1] == src_b[DW-1]) && (sum[DW-1] != src_a[DW-1]);
    assign sub_ov   = (src_a[DW-1] != src_b[DW-1]) && (diff[DW-1] != src_a[DW-1]);
    assign overflow = ALU_Control == 3'b010 ? add_ov : ALU_Control == 3'b110 ? sub_ov : 1'b0;
    assign zero     = res == '0;

    assign npc = PCSource == 2'b00 ? res :
                 PCSource == 2'b01 ? alu_out_r :
                 PCSource == 2'b10 ? {pc[DW-1:28], ir[25:0], 2'b00} : a;
    assign pc_en = PCWrite | (PCWriteCond & (zero ^ BranchNE));

    assign M_addr   = IorD ? alu_out_r : pc;
    assign Data_out = b;
    assign inst_out = ir;
    assign PC_out   = pc;
    assign ALU_out  = res;
    assign unused   = ^{ir, Data_in};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc        <= RESET_PC;
            ir        <= '0;
            mdr       <= '0;
            a         <= '0;
            b         <= '0;
            alu_out_r <= '0;
            for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
        end else begin
            mdr       <= Data_in;
            a         <= regs[rs];
            b         <= regs[rt];
            alu_out_r <= res;
            if (IRWrite) ir <= Data_in[31:0];
            if (pc_en) pc <= npc;
            // Register 0 is never written, so it always reads back as zero.
            if (RegWrite && wa != '0) regs[wa] <= wd;
        end
    end
endmodule

// File: tb/tb_mc_data_path.sv
// tb_mc_data_path: drives a 32-bit and a 64-bit mc_data_path with identical phase
// sequences and checks both against an architectural model every cycle.
module tb_mc_data_path;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst = 1'b1;

    logic PCWrite = 0, PCWriteCond = 0, BranchNE = 0, IorD = 0, IRWrite = 0;
    logic RegWrite = 0, ALUSrcA = 0;
    logic [1:0] RegDst = 0, MemtoReg = 0, ALUSrcB = 0, PCSource = 0;
    logic [2:0] ALU_Control = 0;
    logic [63:0] din = 0;

    logic [31:0] ma32, do32, io32, pc32, al32, io64;
    logic [63:0] ma64, do64, pc64, al64;
    logic z32, ov32, z64, ov64;

    int errors = 0, checks = 0;

    mc_data_path #(.DW(32)) u32 (
        .clk(clk), .rst(rst), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNE(BranchNE),
        .IorD(IorD), .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALU_Control(ALU_Control), .PCSource(PCSource),
        .Data_in(din[31:0]), .M_addr(ma32), .Data_out(do32), .inst_out(io32), .PC_out(pc32),
        .ALU_out(al32), .zero(z32), .overflow(ov32));

    mc_data_path #(.DW(64)) u64 (
        .clk(clk), .rst(rst), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNE(BranchNE),
        .IorD(IorD), .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALU_Control(ALU_Control), .PCSource(PCSource),
        .Data_in(din), .M_addr(ma64), .Data_out(do64), .inst_out(io64), .PC_out(pc64),
        .ALU_out(al64), .zero(z64), .overflow(ov64));

    // Architectural model, index 0 = 32-bit datapath, index 1 = 64-bit datapath.
    logic [63:0] m_pc [2], m_mdr [2], m_a [2], m_b [2], m_ao [2];
    logic [31:0] m_ir [2];
    logic [63:0] m_r [2][32];

    function automatic logic [63:0] msk(input int w);
        return w != 0 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    endfunction

    function automatic logic signed [65:0] sg(input int w, input logic [63:0] x);
        return w != 0 ? {{2{x[63]}}, x} : {{34{x[31]}}, x[31:0]};
    endfunction

    function automatic logic [63:0] m_x(input int w);
        return ALUSrcA ? m_a[w] : m_pc[w];
    endfunction

    function automatic logic [63:0] m_y(input int w);
        logic [63:0] sx;
        sx = {{48{m_ir[w][15]}}, m_ir[w][15:0]} & msk(w);
        case (ALUSrcB)
            2'b00: return m_b[w];
            2'b01: return w != 0 ? 64'd8 : 64'd4;
            2'b10: return sx;
            default: return (sx << 2) & msk(w);
        endcase
    endfunction

    function automatic logic [63:0] m_res(input int w);
        logic [63:0] x, y, r;
        x = m_x(w);
        y = m_y(w);
        case (ALU_Control)
            3'b000: r = x & y;
            3'b001: r = x | y;
            3'b010: r = x + y;
            3'b011: r = x ^ y;
            3'b100: r = ~(x | y);
            3'b110: r = x - y;
            3'b111: r = (sg(w, x) < sg(w, y)) ? 64'd1 : 64'd0;
            default: r = (x < y) ? 64'd1 : 64'd0;
        endcase
        return r & msk(w);
    endfunction

    // Overflow as "true signed result does not fit in DW bits".
    function automatic logic m_ov(input int w);
        logic signed [65:0] s, lim;
        lim = 66'sd1 <<< (w != 0 ? 63 : 31);
        s = ALU_Control == 3'b010 ? sg(w, m_x(w)) + sg(w, m_y(w)) : sg(w, m_x(w)) - sg(w, m_y(w));
        return (ALU_Control == 3'b010 || ALU_Control == 3'b110) && (s >= lim || s < -lim);
    endfunction

    function automatic logic [63:0] m_npc(input int w);
        case (PCSource)
            2'b00: return m_res(w);
            2'b01: return m_ao[w];
            2'b10: return ((m_pc[w] & ~64'h0FFF_FFFF) | {36'b0, m_ir[w][25:0], 2'b00}) & msk(w);
            default: return m_a[w];
        endcase
    endfunction

    function automatic int m_dst(input int w);
        return RegDst == 2'b01 ? int'(m_ir[w][15:11]) : RegDst == 2'b10 ? 31 : int'(m_ir[w][20:16]);
    endfunction

    function automatic logic [63:0] m_wb(input int w);
        return MemtoReg == 2'b01 ? m_mdr[w] : MemtoReg == 2'b10 ? m_pc[w] : m_ao[w];
    endfunction

    function automatic logic m_taken(input int w);
        return PCWrite || (PCWriteCond && ((m_res(w) == 64'd0) != BranchNE));
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int w = 0; w < 2; w++) begin
                m_pc[w] <= 64'd0;
                m_ir[w] <= 32'd0;
                m_mdr[w] <= 64'd0;
                m_a[w] <= 64'd0;
                m_b[w] <= 64'd0;
                m_ao[w] <= 64'd0;
                for (int i = 0; i < 32; i++) m_r[w][i] <= 64'd0;
            end
        end else begin
            for (int w = 0; w < 2; w++) begin
                m_mdr[w] <= din & msk(w);
                m_a[w] <= m_r[w][m_ir[w][25:21]];
                m_b[w] <= m_r[w][m_ir[w][20:16]];
                m_ao[w] <= m_res(w);
                if (IRWrite) m_ir[w] <= din[31:0];
                if (m_taken(w)) m_pc[w] <= m_npc(w);
                if (RegWrite && m_dst(w) != 0) m_r[w][m_dst(w)] <= m_wb(w);
            end
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cmp(input int w, input logic [63:0] ma, dout, inst, pc, alu, input logic z, ov);
        string p;
        p = w != 0 ? "w64" : "w32";
        check({p, "_maddr"}, ma, IorD ? m_ao[w] : m_pc[w]);
        check({p, "_dout"}, dout, m_b[w]);
        check({p, "_inst"}, inst, 64'(m_ir[w]));
        check({p, "_pc"}, pc, m_pc[w]);
        check({p, "_alu"}, alu, m_res(w));
        check({p, "_zero"}, 64'(z), 64'(m_res(w) == 64'd0));
        check({p, "_ovf"}, 64'(ov), 64'(m_ov(w)));
    endtask

    always @(negedge clk) begin
        if (rst) begin
            cmp(0, 64'(ma32), 64'(do32), 64'(io32), 64'(pc32), 64'(al32), z32, ov32);
            cmp(1, ma64, do64, 64'(io64), pc64, al64, z64, ov64);
        end
    end

    task automatic drv(input logic pcw, pcwc, bne, iord, irw, input logic [1:0] rdst, m2r,
                       input logic rw, srca, input logic [1:0] srcb, input logic [2:0] aluc,
                       input logic [1:0] psrc);
        PCWrite = pcw; PCWriteCond = pcwc; BranchNE = bne; IorD = iord; IRWrite = irw;
        RegDst = rdst; MemtoReg = m2r; RegWrite = rw; ALUSrcA = srca; ALUSrcB = srcb;
        ALU_Control = aluc; PCSource = psrc;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        drv(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 3'b000, 2'b00);
        tick;
    endtask

    task automatic fetch(input logic [31:0] word);
        din = {32'b0, word};
        drv(1, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0, 2'b01, 3'b010, 2'b00);
        tick;
    endtask

    task automatic exec_imm;
        drv(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b10, 3'b010, 2'b00);
        tick;
    endtask

    task automatic wb(input logic [1:0] m2r);
        drv(0, 0, 0, 0, 0, 2'b00, m2r, 1, 0, 2'b00, 3'b000, 2'b00);
        tick;
    endtask

    task automatic addi(input logic [31:0] word);
        fetch(word);
        idle;
        exec_imm;
        wb(2'b00);
    endtask

    task automatic lw(input logic [4:0] rt, input logic [31:0] val);
        fetch(32'h8C00_0100 | (32'(rt) << 16));
        idle;
        exec_imm;
        din = {32'b0, val};
        drv(0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 2'b00, 3'b000, 2'b00);
        #1 check("lw_maddr", 64'(ma32), 64'h100);
        tick;
        wb(2'b01);
    endtask

    initial begin
        #3 rst = 1'b0;
        #14 rst = 1'b1;
        tick;
        check("rst_pc32", 64'(pc32), 64'h0);
        check("rst_pc64", pc64, 64'h0);
        check("rst_ir", 64'(io32), 64'h0);
        // fetch
        din = 64'h2008_0005;
        drv(1, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0, 2'b01, 3'b010, 2'b00);
        #1 check("fetch_maddr", 64'(ma32), 64'h0);
        tick;
        check("fetch_ir", 64'(io32), 64'h2008_0005);
        check("fetch_pc32", 64'(pc32), 64'h4);
        check("fetch_pc64", pc64, 64'h8);
        idle;
        exec_imm;
        wb(2'b00);
        addi(32'h2009_0005);
        addi(32'h2000_0007);
        idle;
        check("r0_zero", 64'(do32), 64'h0);
        // beq taken: decode computes PC+8 into ALUOut
        fetch(32'h1109_0002);
        drv(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b11, 3'b010, 2'b00);
        tick;
        check("b_r9", 64'(do32), 64'h5);
        drv(0, 1, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b00, 3'b110, 2'b01);
        #1 check("beq_zero", 64'(z32), 64'h1);
        tick;
        check("beq_pc", 64'(pc32), 64'd24);
        // bne not taken
        fetch(32'h1509_0002);
        drv(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b11, 3'b010, 2'b00);
        tick;
        drv(0, 1, 1, 0, 0, 2'b00, 2'b00, 0, 1, 2'b00, 3'b110, 2'b01);
        tick;
        check("bne_pc", 64'(pc32), 64'd28);
        // jal then jr
        fetch(32'h0C00_0010);
        drv(1, 0, 0, 0, 0, 2'b10, 2'b10, 1, 0, 2'b00, 3'b000, 2'b10);
        tick;
        check("jal_pc", 64'(pc32), 64'h40);
        fetch(32'h03E0_0008);
        idle;
        drv(1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 3'b000, 2'b11);
        tick;
        check("jr_pc32", 64'(pc32), 64'd32);
        check("jr_pc64", pc64, 64'd56);
        // load path
        lw(5'd10, 32'hDEAD_BEEF);
        idle;
        check("lw_rt", 64'(do32), 64'hDEAD_BEEF);
        // ALU edges
        lw(5'd11, 32'h7FFF_FFFF);
        lw(5'd12, 32'h0000_0001);
        lw(5'd13, 32'hFFFF_FFFF);
        fetch(32'h016C_0000);
        idle;
        drv(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b00, 3'b010, 2'b00);
        #1 check("add_ovf32", 64'(ov32), 64'h1);
        check("add_sum32", 64'(al32), 64'h8000_0000);
        check("add_ovf64", 64'(ov64), 64'h0);
        tick;
        fetch(32'h01AC_0000);
        idle;
        drv(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b00, 3'b111, 2'b00);
        #1 check("slt", 64'(al32), 64'h1);
        ALU_Control = 3'b101;
        #1 check("sltu", 64'(al32), 64'h0);
        tick;
        // asynchronous reset between edges
        #1 rst = 1'b0;
        #1 check("arst_pc32", 64'(pc32), 64'h0);
        check("arst_pc64", pc64, 64'h0);
        check("arst_ir", 64'(io32), 64'h0);
        #1 rst = 1'b1;
        fetch(32'h2008_0005);
        check("restart_pc", 64'(pc32), 64'h4);
        check("restart_ir", 64'(io32), 64'h2008_0005);
        idle;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
